mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the instruction-cache and data-cache RAM requests of up to two cores onto the single RAM port. It sits directly downstream of every icache/dcache pair and upstream of the RAM model. Data-cache requests take precedence over instruction fetches, and cores are served round-robin. A data-cache two-word block transfer stays granted from its first word through its second, so block fills and write-backs are never interleaved with another requester.

## Interface
- CPUS, default 2, number of cores served; legal values are 1 and 2.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  [CPUS]  icache read request.
- iaddr  in  [CPUS] x 32  icache word address.
- iwait  out  [CPUS]  high = icache must hold its request.
- iload  out  [CPUS] x 32  fetched word.
- dREN, dWEN  in  [CPUS]  dcache read/write request.
- daddr, dstore  in  [CPUS] x 32  dcache address and write data.
- dwait  out  [CPUS]  high = dcache must hold its request.
- dload  out  [CPUS] x 32  read word.
- ramREN, ramWEN  out  1  RAM read/write strobe.
- ramaddr, ramstore  out  32  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS or ERROR.

## Operation
- A core's d-request is dREN|dWEN. If both are high, it is a write. A core's i-request is iREN.
- Owner register {cpu, isD}, a round-robin pointer rr (1 bit) and the state machine are all reset asynchronously.
- State machine: IDLE, SERVE, LOCKED.
- IDLE
  - RAM strobes are 0.
  - If any request is pending, latch the winner as owner and go to SERVE.
  - Winner selection: any d-request beats any i-request. Within a class, the core equal to rr wins, then the other core.
- SERVE
  - The owner's request drives ramREN/ramWEN/ramaddr/ramstore.
  - When ramstate==ACCESS, drop the owner's wait for that cycle.
    - If the owner is a dcache and daddr[2]==0, go to LOCKED.
    - Otherwise go to IDLE and set rr to the other core.
  - If the owner's request deasserts before ACCESS, go to IDLE without changing rr.
- LOCKED
  - Continue driving the owner's dcache request.
  - When ACCESS arrives with daddr[2]==1, go to IDLE and flip rr.
  - When ACCESS arrives with daddr[2]==0, stay in LOCKED.
  - If the owner's dREN|dWEN drops, go to IDLE and flip rr. This case covers halt-flush single writes such as the counter write at 0x3100.
- Every wait output is 1 except the owner's wait during the ACCESS cycle.
- iload and dload for all cores are driven by ramload combinationally. They are valid only when the matching wait is 0.
- ERROR and BUSY are both treated as "not yet": waits stay high and the request stays driven.
- With CPUS==1, rr is tied to 0.

## Timing
- Reset values:
  - State IDLE, owner 0, rr 0.
  - ramREN, ramWEN, ramaddr and ramstore are 0.
  - All iwait and dwait are 1.
  - iload and dload follow ramload.
- Assertion of RST forces all of the above in the same cycle, even in the middle of a transfer. The RAM strobe drops without waiting for ACCESS.
- Grant latency: a request first seen in IDLE is driven to RAM on the next cycle. The access completes in the first cycle where ramstate==ACCESS.
- Zero-latency RAM timing:
  - Single word: request in cycle 0, wait low in cycle 1.
  - Block: first word in cycle 1, second word in cycle 2, with no bubble between words in LOCKED.
- After a completed access, the arbiter returns to IDLE. It always spends one cycle there before the next grant, and that cycle is also where rr takes effect.
- All arbiter outputs are combinational from the registered owner/state and the current inputs. There is no path from ramload into the arbiter's decisions.

## Structure
- Shared package cpu_types_pkg holds:
  - word_t (32-bit).
  - ramstate_t enum: FREE, BUSY, ACCESS, ERROR.
  - arbiter state enum arb_state_t: IDLE, SERVE, LOCKED.
- Module-local struct for the owner: {cpu, isD}.
- One sub-module, mem_arb_pick: combinational winner select. It takes the request vectors and rr and returns the winner, valid, cpu and isD.
- The top-level module contains the state machine, owner/rr registers and output muxing.

## Test plan
- Single core, iREN=1 at iaddr 0x40, RAM returns ACCESS on the second driven cycle with ramload 0xDEADBEEF → ramREN high for 2 cycles; iwait low exactly once; iload=0xDEADBEEF in that cycle.
- Core 0 i-request and core 1 d-request (dREN) raised together → core 1 dcache is granted first; core 0 is granted afterwards.
- Core 0 dcache block read at 0x100 then 0x104, while core 1 holds dREN at 0x200 → both 0x100 and 0x104 complete on consecutive cycles before 0x200 is driven; rr=1 after the release.
- Both cores issue repeated single icache fetches → grants alternate 0,1,0,1 with one IDLE cycle between them.
- Core 0 issues a dWEN at 0x3100 with dstore=5 and then deasserts dWEN → ramWEN with ramstore=5; LOCKED exits on the deassert; core 1 is then served.
- RST pulsed while in LOCKED during ramstate BUSY → ramREN/ramWEN drop the same cycle; all waits are 1; state is IDLE; rr is 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: machine word, RAM status codes and arbiter states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE  = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: d-requests beat i-requests, and within a class
// the core named by rr wins over the other one.
module mem_arb_pick
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic [CPUS-1:0] ireq,
    input  logic [CPUS-1:0] dreq,
    input  logic            rr,
    output logic            valid,
    output logic            cpu,
    output logic            is_d
);

    // Scan lowest priority first so later (higher-priority) hits overwrite.
    always_comb begin
        logic c;
        valid = 1'b0;
        cpu   = 1'b0;
        is_d  = 1'b0;
        c     = 1'b0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            c = (k == 0) ? rr : ~rr;
            if (ireq[c]) begin
                valid = 1'b1;
                cpu   = c;
                is_d  = 1'b0;
            end
        end
        for (int k = CPUS - 1; k >= 0; k--) begin
            c = (k == 0) ? rr : ~rr;
            if (dreq[c]) begin
                valid = 1'b1;
                cpu   = c;
                is_d  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache requests of up to two cores onto one RAM port,
// holding the grant across both words of a dcache block transfer.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CPUS-1:0] iREN,
    input  word_t           iaddr  [CPUS],
    output logic [CPUS-1:0] iwait,
    output word_t           iload  [CPUS],
    input  logic [CPUS-1:0] dREN,
    input  logic [CPUS-1:0] dWEN,
    input  word_t           daddr  [CPUS],
    input  word_t           dstore [CPUS],
    output logic [CPUS-1:0] dwait,
    output word_t           dload  [CPUS],
    output logic            ramREN,
    output logic            ramWEN,
    output word_t           ramaddr,
    output word_t           ramstore,
    input  word_t           ramload,
    input  ramstate_t       ramstate
);

    typedef struct packed {
        logic cpu;
        logic is_d;
    } owner_t;

    arb_state_t state;
    owner_t     owner;
    logic       rr;
    logic       oc;
    logic       pick_valid;
    logic       pick_cpu;
    logic       pick_is_d;
    logic       own_req;
    logic       done;
    logic       last_word;
    logic       next_rr;

    assign oc      = owner.cpu;
    assign next_rr = (CPUS > 1) ? ~owner.cpu : 1'b0;

    mem_arb_pick #(.CPUS(CPUS)) u_pick (
        .ireq  (iREN),
        .dreq  (dREN | dWEN),
        .rr    (rr),
        .valid (pick_valid),
        .cpu   (pick_cpu),
        .is_d  (pick_is_d)
    );

    // An i-fetch is always a single word; a d-access is the last word once addr[2] is set.
    always_comb begin
        own_req   = owner.is_d ? (dREN[oc] | dWEN[oc]) : iREN[oc];
        done      = (state != IDLE) && own_req && (ramstate == ACCESS);
        last_word = !owner.is_d || daddr[oc][2];
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        if (state != IDLE) begin
            if (owner.is_d) begin
                ramWEN   = dWEN[oc];
                ramREN   = dREN[oc] & ~dWEN[oc];
                ramaddr  = daddr[oc];
                ramstore = dstore[oc];
                if (done) dwait[oc] = 1'b0;
            end else begin
                ramREN  = iREN[oc];
                ramaddr = iaddr[oc];
                if (done) iwait[oc] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CPUS; i++) begin
            iload[i] = ramload;
            dload[i] = ramload;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            owner <= '0;
            rr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= '{cpu: pick_cpu, is_d: pick_is_d};
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (!own_req) begin
                        state <= IDLE;
                    end else if (done) begin
                        if (last_word) begin
                            state <= IDLE;
                            rr    <= next_rr;
                        end else begin
                            state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    // A dropped request (halt-flush single write) also releases the lock.
                    if (!own_req || (done && last_word)) begin
                        state <= IDLE;
                        rr    <= next_rr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with two cores and a hand-driven RAM status.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      RST;
    logic [1:0] iREN;
    word_t     iaddr  [2];
    logic [1:0] iwait;
    word_t     iload  [2];
    logic [1:0] dREN;
    logic [1:0] dWEN;
    word_t     daddr  [2];
    word_t     dstore [2];
    logic [1:0] dwait;
    word_t     dload  [2];
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.CPUS(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = '0;
        dREN = '0;
        dWEN = '0;
        for (int i = 0; i < 2; i++) begin
            iaddr[i]  = '0;
            daddr[i]  = '0;
            dstore[i] = '0;
        end
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        ramload  = 32'h1234_5678;
        ramstate = FREE;
        #2;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_iwait", iwait, 2'b11);
        chk("rst_dwait", dwait, 2'b11);
        chk("rst_state", dut.state, IDLE);
        chk("rst_rr", dut.rr, 0);
        chk("rst_iload1", iload[1], 32'h1234_5678);
        chk("rst_dload0", dload[0], 32'h1234_5678);
        #1 RST = 1'b0;

        // Single i-fetch; ERROR counts as not-yet, ACCESS on second driven cycle.
        tick();
        iREN[0] = 1'b1; iaddr[0] = 32'h40; ramstate = ERROR;
        #2;
        chk("t1_idle_ramREN", ramREN, 0);
        chk("t1_idle_iwait", iwait, 2'b11);
        tick();
        #2;
        chk("t1_c1_ramREN", ramREN, 1);
        chk("t1_c1_ramaddr", ramaddr, 32'h40);
        chk("t1_c1_iwait", iwait, 2'b11);
        tick();
        ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
        #2;
        chk("t1_c2_ramREN", ramREN, 1);
        chk("t1_c2_iwait", iwait, 2'b10);
        chk("t1_c2_iload", iload[0], 32'hDEAD_BEEF);
        tick();
        iREN = '0; ramstate = FREE;
        #2;
        chk("t1_end_ramREN", ramREN, 0);
        chk("t1_end_iwait", iwait, 2'b11);
        chk("t1_end_rr", dut.rr, 1);
        chk("t1_end_state", dut.state, IDLE);

        // Core 0 i-request vs core 1 d-request raised together.
        tick();
        iREN[0] = 1'b1; iaddr[0] = 32'h80;
        dREN[1] = 1'b1; daddr[1] = 32'h204;
        ramstate = ACCESS; ramload = 32'hA5A5_0001;
        #2;
        chk("t2_idle_ramREN", ramREN, 0);
        tick();
        #2;
        chk("t2_d1_ramaddr", ramaddr, 32'h204);
        chk("t2_d1_ramREN", ramREN, 1);
        chk("t2_d1_dwait", dwait, 2'b01);
        chk("t2_d1_iwait", iwait, 2'b11);
        chk("t2_d1_dload", dload[1], 32'hA5A5_0001);
        tick();
        dREN[1] = 1'b0;
        #2;
        chk("t2_gap_ramREN", ramREN, 0);
        chk("t2_gap_rr", dut.rr, 0);
        tick();
        #2;
        chk("t2_i0_ramaddr", ramaddr, 32'h80);
        chk("t2_i0_iwait", iwait, 2'b10);
        tick();
        iREN[0] = 1'b0;
        #2;
        chk("t2_end_rr", dut.rr, 1);
        #1 RST = 1'b1;
        #1 RST = 1'b0;
        #1;
        chk("idle_rst_rr", dut.rr, 0);

        // Both cores fetch continuously: grants alternate with an IDLE cycle between.
        tick();
        iREN = 2'b11; iaddr[0] = 32'h1000; iaddr[1] = 32'h2000; ramstate = ACCESS;
        for (int g = 0; g < 4; g++) begin
            #2;
            chk("t4_idle_ramREN", ramREN, 0);
            tick();
            #2;
            chk("t4_grant_addr", ramaddr, (g % 2 == 0) ? 32'h1000 : 32'h2000);
            chk("t4_grant_iwait", iwait, (g % 2 == 0) ? 32'h2 : 32'h1);
            tick();
        end
        iREN = '0;
        #2;
        chk("t4_end_rr", dut.rr, 0);

        // Core 0 block read 0x100/0x104 while core 1 waits at 0x200.
        tick();
        dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h200; ramload = 32'h1111_1111;
        #2;
        chk("t3_idle_ramREN", ramREN, 0);
        chk("t3_idle_dwait", dwait, 2'b11);
        tick();
        #2;
        chk("t3_w0_addr", ramaddr, 32'h100);
        chk("t3_w0_ramREN", ramREN, 1);
        chk("t3_w0_dwait", dwait, 2'b10);
        chk("t3_w0_dload", dload[0], 32'h1111_1111);
        tick();
        daddr[0] = 32'h104; ramload = 32'h2222_2222;
        #2;
        chk("t3_w1_addr", ramaddr, 32'h104);
        chk("t3_w1_dwait", dwait, 2'b10);
        chk("t3_w1_state", dut.state, LOCKED);
        chk("t3_w1_dload", dload[0], 32'h2222_2222);
        tick();
        dREN[0] = 1'b0;
        #2;
        chk("t3_rel_ramREN", ramREN, 0);
        chk("t3_rel_rr", dut.rr, 1);
        tick();
        #2;
        chk("t3_c1_addr", ramaddr, 32'h200);
        chk("t3_c1_dwait", dwait, 2'b01);
        tick();
        dREN[1] = 1'b0;
        #2;
        chk("t3_c1_drop_state", dut.state, LOCKED);
        chk("t3_c1_drop_ramREN", ramREN, 0);
        chk("t3_c1_drop_dwait", dwait, 2'b11);
        tick();
        #2;
        chk("t3_end_state", dut.state, IDLE);
        chk("t3_end_rr", dut.rr, 0);

        // Halt-flush write at 0x3100 that deasserts while LOCKED; core 1 follows.
        tick();
        dWEN[0] = 1'b1; daddr[0] = 32'h3100; dstore[0] = 32'd5;
        dREN[1] = 1'b1; daddr[1] = 32'h20C; dstore[1] = 32'h77;
        #2;
        chk("t5_idle_ramWEN", ramWEN, 0);
        tick();
        #2;
        chk("t5_wr_ramWEN", ramWEN, 1);
        chk("t5_wr_ramREN", ramREN, 0);
        chk("t5_wr_addr", ramaddr, 32'h3100);
        chk("t5_wr_store", ramstore, 32'd5);
        chk("t5_wr_dwait", dwait, 2'b10);
        tick();
        dWEN[0] = 1'b0;
        #2;
        chk("t5_lock_state", dut.state, LOCKED);
        chk("t5_lock_ramWEN", ramWEN, 0);
        chk("t5_lock_dwait", dwait, 2'b11);
        tick();
        #2;
        chk("t5_rel_state", dut.state, IDLE);
        chk("t5_rel_rr", dut.rr, 1);
        tick();
        #2;
        chk("t5_c1_ramREN", ramREN, 1);
        chk("t5_c1_addr", ramaddr, 32'h20C);
        chk("t5_c1_store", ramstore, 32'h77);
        chk("t5_c1_dwait", dwait, 2'b01);
        tick();
        dREN[1] = 1'b0;
        #2;
        chk("t5_end_state", dut.state, IDLE);
        chk("t5_end_rr", dut.rr, 0);

        // Reset mid-block while LOCKED and RAM is BUSY.
        tick();
        iREN[0] = 1'b1; iaddr[0] = 32'h40;
        tick();
        tick();
        iREN[0] = 1'b0;
        #2;
        chk("t6_pre_rr", dut.rr, 1);
        tick();
        dREN[1] = 1'b1; daddr[1] = 32'h300;
        tick();
        #2;
        chk("t6_w0_dwait", dwait, 2'b01);
        tick();
        ramstate = BUSY;
        #2;
        chk("t6_lock_state", dut.state, LOCKED);
        chk("t6_lock_ramREN", ramREN, 1);
        chk("t6_lock_dwait", dwait, 2'b11);
        #1 RST = 1'b1;
        #1;
        chk("t6_rst_ramREN", ramREN, 0);
        chk("t6_rst_ramWEN", ramWEN, 0);
        chk("t6_rst_ramaddr", ramaddr, 0);
        chk("t6_rst_iwait", iwait, 2'b11);
        chk("t6_rst_dwait", dwait, 2'b11);
        chk("t6_rst_state", dut.state, IDLE);
        chk("t6_rst_rr", dut.rr, 0);
        RST = 1'b0;
        clear_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
